stage_skid_buf: RTL and testbench
=================================

Name: stage_skid_buf

Overview:
- Parametrised inter-stage pipeline buffer: the next-generation replacement for the fixed IF/ID, ID/EX and EX/MEM buffer arrays in the 16-bit CPU datapath.
- Carries NUM_FIELDS fields of DATA_W bits, packed into one bus, between two pipeline stages.
- Adds a valid/ready handshake, a 2-entry skid so ready is not combinationally chained through stages, and a synchronous flush for branch squash.
- Drives a zero bubble (NOP encoding) when no valid entry is present.

Parameters:
- DATA_W, 16, width of one field in bits.
- NUM_FIELDS, 16, number of fields per entry; the bus width is BUS_W = DATA_W*NUM_FIELDS.
- CNT_W, 16, width of the stall performance counter.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset.
- in_valid  in  1  upstream stage presents an entry.
- in_ready  out  1  buffer accepts the entry this cycle.
- in_data  in  BUS_W  upstream entry; field k occupies bits [k*DATA_W +: DATA_W].
- flush  in  1  squash all held entries.
- out_valid  out  1  entry at output is valid.
- out_ready  in  1  downstream stage consumes the entry this cycle.
- out_data  out  BUS_W  output entry; all zeros when out_valid=0.
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  CNT_W  downstream-stall cycle count (see Optional Feature).

Interface: reset Rst, synchronous, active-low; clock Clk.

Behaviour:
- Storage and state:
  - Two entry registers: MAIN (drives out_data) and SKID.
  - States: EMPTY (occupancy 0), ONE (MAIN valid, occupancy 1), FULL (MAIN and SKID valid, occupancy 2).
- Handshake:
  - acc_in = in_valid & in_ready.
  - acc_out = out_valid & out_ready.
  - in_ready = (state != FULL) & ~flush. It is the only combinational path; there is no in→out combinational path.
  - out_valid = (state != EMPTY), registered.
  - out_data = MAIN when out_valid=1, else 0.
- Transitions (when flush=0):
  - EMPTY, acc_in: MAIN<=in_data, go to ONE.
  - EMPTY, no acc_in: stay EMPTY.
  - ONE, acc_in & acc_out: MAIN<=in_data, stay ONE (full throughput, 1 entry/cycle).
  - ONE, acc_in only: SKID<=in_data, go to FULL.
  - ONE, acc_out only: go to EMPTY.
  - ONE, neither: hold.
  - FULL, acc_out: MAIN<=SKID, go to ONE. in_ready=0, so no simultaneous accept.
  - FULL, no acc_out: hold; MAIN and SKID unchanged.
- Latency:
  - An entry accepted into EMPTY appears at out_data the next cycle.
  - Ordering is strictly FIFO: the MAIN entry is always older than the SKID entry.
- Flush:
  - flush=1 forces the next state to EMPTY regardless of other inputs.
  - The in_data offered in a flush cycle is not accepted (in_ready=0).
  - out_ready in a flush cycle has no effect on anything except stall_cnt.
  - MAIN and SKID contents are not cleared; out_data reads 0 because out_valid=0.
- Reset:
  - When Rst=0 at a clock edge: state EMPTY, MAIN=0, SKID=0, stall_cnt=0.
  - Resulting outputs: out_valid=0, out_data=0, occupancy=0.
  - in_ready=0 during reset cycles.
  - Reset asserted mid-transfer discards all held entries, with no partial update.
  - Reset has priority over flush.
- Data is never modified. Field packing is positional only; no per-field logic.

Optional Feature:
- Macro: STAGE_SKID_BUF_PERF_EN.
- Defined:
  - stall_cnt increments on every clock with out_valid=1 & out_ready=0, including flush cycles.
  - Saturates at all-ones, with no wrap.
  - Cleared only by reset, not by flush.
- Undefined: no counter register is built; stall_cnt is tied to 0.

Test Plan:
- Reset then idle: hold Rst=0 two cycles, release; in_valid=0 → out_valid=0, out_data=0, occupancy=0, in_ready=1 after release.
- Streaming: out_ready=1, in_valid=1 for 4 cycles with field0=16'h0001..16'h0004 → out_data field0 = 1,2,3,4 on cycles 1..4 after each accept, occupancy stays 1, in_ready stays 1.
- Backpressure: out_ready=0, push 16'hAAAA then 16'hBBBB → occupancy=2, in_ready=0, third push not accepted. Raise out_ready → outputs AAAA, then BBBB, then out_valid=0; no loss or duplication.
- Flush in FULL: with AAAA and BBBB held, assert flush with in_valid=1, in_data=CCCC → next cycle occupancy=0, out_valid=0, out_data=0; CCCC never appears at the output.
- Reset mid-operation: hold FULL, assert Rst=0 for one cycle with out_ready=1 → occupancy=0, out_valid=0, no entry emitted afterwards.
- Perf counter (macro defined): out_valid=1, out_ready=0 for 5 cycles, then a flush → stall_cnt=5, and stays 5 after the flush. With CNT_W=2 and 6 stall cycles → stall_cnt=3 (saturated). Macro undefined → stall_cnt=0 throughout.

Source files
------------

// File: rtl/stage_skid_buf.sv
// Two-entry skid buffer between pipeline stages: valid/ready handshake, branch flush, zero bubble when empty.
// Optional STAGE_SKID_BUF_PERF_EN builds a saturating downstream-stall counter; otherwise stall_cnt is tied to 0.
module stage_skid_buf #(
    parameter int DATA_W     = 16,
    parameter int NUM_FIELDS = 16,
    parameter int CNT_W      = 16,
    localparam int BUS_W     = DATA_W * NUM_FIELDS
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BUS_W-1:0] main_q, main_d;
    logic [BUS_W-1:0] skid_q, skid_d;
    logic             acc_in, acc_out;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Ready depends only on held state and flush, so it never chains through upstream stages.
    assign acc_in  = in_valid & in_ready;
    assign acc_out = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_in) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc_in && acc_out) begin
                        main_d = in_data;
                    end else if (acc_in) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (acc_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (acc_out) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = Rst & ~flush & (state_q != ST_FULL);
        out_valid = (state_q != ST_EMPTY);
        out_data  = out_valid ? main_q : '0;
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

`ifdef STAGE_SKID_BUF_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Counts flush cycles too; only reset clears it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !(&stall_q))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_skid_buf.sv
// Bench for stage_skid_buf: directed test-plan steps then random traffic, checked against a queue model.
module tb_stage_skid_buf;
    localparam int DW  = 16;
    localparam int NF  = 4;
    localparam int BW  = DW * NF;
    localparam int CW  = 16;
    localparam int CW2 = 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [BW-1:0] in_data = '0;

    logic          in_ready, out_valid;
    logic [BW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    logic          in_ready2, out_valid2;
    logic [BW-1:0] out_data2;
    logic [1:0]    occupancy2;
    logic [CW2-1:0] stall_cnt2;

    stage_skid_buf #(.DATA_W(DW), .NUM_FIELDS(NF), .CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    stage_skid_buf #(.DATA_W(DW), .NUM_FIELDS(NF), .CNT_W(CW2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    always #5 Clk = ~Clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [BW-1:0] mq[$];
    int unsigned   m_cnt  = 0;
    int unsigned   m_cnt2 = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model at the edge.
    task automatic step(input logic r, input logic iv, input logic [BW-1:0] d,
                        input logic fl, input logic orr);
        logic          exp_rdy;
        logic [BW-1:0] exp_data;
        @(negedge Clk);
        Rst = r; in_valid = iv; in_data = d; flush = fl; out_ready = orr;
        #1;
        exp_rdy  = r && !fl && (mq.size() < 2);
        exp_data = (mq.size() > 0) ? mq[0] : '0;
        chk("in_ready",   BW'(in_ready),   BW'(exp_rdy));
        chk("out_valid",  BW'(out_valid),  BW'(mq.size() > 0));
        chk("out_data",   out_data,        exp_data);
        chk("occupancy",  BW'(occupancy),  BW'(mq.size()));
        chk("occupancy2", BW'(occupancy2), BW'(mq.size()));
`ifdef STAGE_SKID_BUF_PERF_EN
        chk("stall_cnt",  BW'(stall_cnt),  BW'(m_cnt));
        chk("stall_cnt2", BW'(stall_cnt2), BW'(m_cnt2));
`else
        chk("stall_cnt",  BW'(stall_cnt),  '0);
        chk("stall_cnt2", BW'(stall_cnt2), '0);
`endif
        @(posedge Clk);
        if (!r) begin
            mq.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            if (mq.size() > 0 && !orr) begin
                if (m_cnt  < (1 << CW)  - 1) m_cnt++;
                if (m_cnt2 < (1 << CW2) - 1) m_cnt2++;
            end
            if (fl) mq.delete();
            else begin
                if (mq.size() > 0 && orr) void'(mq.pop_front());
                if (exp_rdy && iv) mq.push_back(d);
            end
        end
        #1;
    endtask

    initial begin
        logic [BW-1:0] d;
        // Bring state out of X before any comparison.
        @(posedge Clk);
        #1;

        // Reset then idle
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("idle_in_ready", BW'(in_ready), BW'(1));
        chk("idle_out_data", out_data, '0);

        // Streaming at full throughput
        for (int i = 1; i <= 4; i++) begin
            d = BW'(i);
            step(1'b1, 1'b1, d, 1'b0, 1'b1);
            chk("stream_f0",  BW'(out_data[DW-1:0]), BW'(i));
            chk("stream_occ", BW'(occupancy), BW'(1));
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Backpressure: third push refused, then drain in order
        step(1'b1, 1'b1, BW'(16'hAAAA), 1'b0, 1'b0);
        step(1'b1, 1'b1, BW'(16'hBBBB), 1'b0, 1'b0);
        chk("bp_occ",   BW'(occupancy), BW'(2));
        chk("bp_ready", BW'(in_ready),  BW'(0));
        step(1'b1, 1'b1, BW'(16'hCCCC), 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("bp_drain1", out_data, BW'(16'hBBBB));
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("bp_drain2", BW'(out_valid), BW'(0));
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Flush while FULL
        step(1'b1, 1'b1, BW'(16'hAAAA), 1'b0, 1'b0);
        step(1'b1, 1'b1, BW'(16'hBBBB), 1'b0, 1'b0);
        step(1'b1, 1'b1, BW'(16'hCCCC), 1'b1, 1'b0);
        chk("flush_occ",  BW'(occupancy), BW'(0));
        chk("flush_data", out_data, '0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Reset while FULL with downstream ready
        step(1'b1, 1'b1, BW'(16'h1111), 1'b0, 1'b0);
        step(1'b1, 1'b1, BW'(16'h2222), 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("rst_occ",   BW'(occupancy), BW'(0));
        chk("rst_valid", BW'(out_valid), BW'(0));
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Stall counter: five stalled cycles, then a flush with downstream ready
        step(1'b1, 1'b1, BW'(16'h5555), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
`ifdef STAGE_SKID_BUF_PERF_EN
        chk("perf_cnt5", BW'(stall_cnt),  BW'(5));
        chk("perf_sat",  BW'(stall_cnt2), BW'(3));
`else
        chk("perf_off",  BW'(stall_cnt),  '0);
`endif

        // Random traffic with occasional flush/reset and long stall stretches
        for (int i = 0; i < 400; i++) begin
            d = {$urandom, $urandom};
            step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), d,
                 ($urandom_range(0, 7) == 0),
                 ((i % 50) < 15) ? 1'b0 : 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
